mem_master: RTL and testbench

Memory-access initiator for the LC-3b datapath. It accepts load/store requests from the control unit, drives the byte-lane 16-bit memory (even/odd 8-bit banks, word/byte select, active-low lane write enables, ready flag), and waits for memory ready. It then returns sign-extended or full-word read data, or an error, over a valid/ready response handshake. It is the requesting end of the memory interface and sits between the MAR/MDR logic and the memory block.

---
 rtl/mem_pkg.sv | 19 +
 rtl/mem_lane_sel.sv | 41 ++++
 rtl/mem_master.sv | 168 ++++++++++++++++
 tb/tb_mem_master.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_pkg : shared types and constants for the memory initiator    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;
  localparam int   LANE_W    = 8;

endpackage
`default_nettype wire

// File: rtl/mem_lane_sel.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_lane_sel : store lane replicate/enable decode, load extract  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module mem_lane_sel
  import mem_pkg::*;
(
  input  logic                st_word,
  input  logic                st_odd,
  input  logic [2*LANE_W-1:0] st_data,
  output logic [2*LANE_W-1:0] st_lanes,
  output logic                st_we_even_n,
  output logic                st_we_odd_n,
  input  logic                ld_word,
  input  logic                ld_odd,
  input  logic [2*LANE_W-1:0] ld_data,
  output logic [2*LANE_W-1:0] ld_result
);

  logic [LANE_W-1:0] w_ld_byte;

  // Byte stores drive the low byte on both lanes; only the addressed lane is enabled.
  always_comb begin
    if (st_word == SIZE_WORD) begin
      st_lanes     = st_data;
      st_we_even_n = 1'b0;
      st_we_odd_n  = 1'b0;
    end else begin
      st_lanes     = {2{st_data[LANE_W-1:0]}};
      st_we_even_n = st_odd;
      st_we_odd_n  = ~st_odd;
    end
  end

  assign w_ld_byte = ld_odd ? ld_data[2*LANE_W-1:LANE_W] : ld_data[LANE_W-1:0];
  assign ld_result = (ld_word == SIZE_BYTE) ? {{LANE_W{w_ld_byte[LANE_W-1]}}, w_ld_byte}
                                            : ld_data;

endmodule
`default_nettype wire

// File: rtl/mem_master.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_master : LC-3b load/store initiator for the byte-lane memory |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module mem_master
  import mem_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_word,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_word,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we_even_n,
  output logic              mem_we_odd_n,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam logic [7:0] c_wait_last = 8'(WAIT_MAX - 1);

  state_t            r_state, w_state_nx;
  logic [ADDR_W-1:0] r_addr, w_addr_nx;
  logic              r_word, w_word_nx;
  logic              r_we, w_we_nx;
  logic [DATA_W-1:0] r_wdata, w_wdata_nx;
  logic [DATA_W-1:0] r_rdata, w_rdata_nx;
  logic              r_err, w_err_nx;
  logic              r_we_even_n, w_we_even_n_nx;
  logic              r_we_odd_n, w_we_odd_n_nx;
  logic [7:0]        r_cnt, w_cnt_nx;
  logic              r_req_ready, r_rsp_valid;
  logic [DATA_W-1:0] w_st_lanes, w_ld_result;
  logic              w_st_even_n, w_st_odd_n;

  mem_lane_sel u_lane_sel (
    .st_word      (req_word),
    .st_odd       (req_addr[0]),
    .st_data      (req_wdata),
    .st_lanes     (w_st_lanes),
    .st_we_even_n (w_st_even_n),
    .st_we_odd_n  (w_st_odd_n),
    .ld_word      (r_word),
    .ld_odd       (r_addr[0]),
    .ld_data      (mem_rdata),
    .ld_result    (w_ld_result)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_word      <= 1'b0;
      r_we        <= 1'b0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_we_even_n <= 1'b1;
      r_we_odd_n  <= 1'b1;
      r_cnt       <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_addr      <= w_addr_nx;
      r_word      <= w_word_nx;
      r_we        <= w_we_nx;
      r_wdata     <= w_wdata_nx;
      r_rdata     <= w_rdata_nx;
      r_err       <= w_err_nx;
      r_we_even_n <= w_we_even_n_nx;
      r_we_odd_n  <= w_we_odd_n_nx;
      r_cnt       <= w_cnt_nx;
      r_req_ready <= (w_state_nx == IDLE);
      r_rsp_valid <= (w_state_nx == RESP);
    end
  end

  // Enables are registered, so they are decided one edge ahead of the cycle they cover.
  always_comb begin
    w_state_nx     = r_state;
    w_addr_nx      = r_addr;
    w_word_nx      = r_word;
    w_we_nx        = r_we;
    w_wdata_nx     = r_wdata;
    w_rdata_nx     = r_rdata;
    w_err_nx       = r_err;
    w_we_even_n_nx = 1'b1;
    w_we_odd_n_nx  = 1'b1;
    w_cnt_nx       = r_cnt;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_addr_nx  = req_addr;
          w_word_nx  = req_word;
          w_we_nx    = req_we;
          w_wdata_nx = w_st_lanes;
          w_rdata_nx = '0;
          w_err_nx   = 1'b0;
          w_cnt_nx   = '0;
          if (req_word && req_addr[0]) begin
            w_state_nx = RESP;
            w_err_nx   = 1'b1;
          end else begin
            w_state_nx = ACCESS;
            if (req_we) begin
              w_we_even_n_nx = w_st_even_n;
              w_we_odd_n_nx  = w_st_odd_n;
            end
          end
        end
      end
      ACCESS: begin
        w_we_even_n_nx = r_we_even_n;
        w_we_odd_n_nx  = r_we_odd_n;
        if (mem_ready) begin
          w_state_nx     = RESP;
          w_rdata_nx     = r_we ? '0 : w_ld_result;
          w_err_nx       = 1'b0;
          w_we_even_n_nx = 1'b1;
          w_we_odd_n_nx  = 1'b1;
        end else if (r_cnt == c_wait_last) begin
          w_state_nx     = RESP;
          w_rdata_nx     = '0;
          w_err_nx       = 1'b1;
          w_we_even_n_nx = 1'b1;
          w_we_odd_n_nx  = 1'b1;
        end else begin
          w_cnt_nx = r_cnt + 8'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          w_state_nx = IDLE;
          w_rdata_nx = '0;
          w_err_nx   = 1'b0;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  assign req_ready     = r_req_ready;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_rdata     = r_rdata;
  assign rsp_err       = r_err;
  assign mem_addr      = r_addr;
  assign mem_word      = r_word;
  assign mem_wdata     = r_wdata;
  assign mem_we_even_n = r_we_even_n;
  assign mem_we_odd_n  = r_we_odd_n;

endmodule
`default_nettype wire

// File: tb/tb_mem_master.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mem_master : directed self-checking bench with response queue |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_mem_master;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0, req_word = 1'b0;
  logic [15:0] req_addr = '0, req_wdata = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [15:0] rsp_rdata, mem_addr, mem_wdata;
  logic        mem_word, mem_we_even_n, mem_we_odd_n;
  logic [15:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;

  int tests = 0;
  int fails = 0;
  logic [16:0] sb[$];

  mem_master #(.ADDR_W(16), .DATA_W(16), .WAIT_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_word(req_word),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_word(mem_word), .mem_wdata(mem_wdata),
    .mem_we_even_n(mem_we_even_n), .mem_we_odd_n(mem_we_odd_n),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transaction: push the expected response, drive the request, watch ACCESS, then drain.
  task automatic do_req(input logic we, input logic word, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [15:0] rdin, input int delay,
                        input logic [15:0] exp_rd, input logic exp_err, input int exp_lat,
                        input logic [1:0] exp_en_n, input logic [15:0] exp_mwd, input int hold);
    logic [16:0] e;
    int lat;
    sb.push_back({exp_err, exp_rd});
    req_valid = 1'b1; req_we = we; req_word = word; req_addr = addr; req_wdata = wdata;
    mem_rdata = rdin; mem_ready = 1'b0;
    chk("req_ready_idle", req_ready, 1);
    tick;
    req_valid = 1'b0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat <= 40) begin
      chk("access_en_n", {mem_we_even_n, mem_we_odd_n}, exp_en_n);
      chk("access_addr", mem_addr, addr);
      chk("access_word", mem_word, word);
      chk("access_req_ready", req_ready, 0);
      if (we) chk("access_wdata", mem_wdata, exp_mwd);
      mem_ready = ((lat - 1) >= delay);
      tick;
      lat++;
    end
    mem_ready = 1'b0;
    chk("latency", lat, exp_lat);
    e = sb.pop_front();
    for (int h = 0; h <= hold; h++) begin
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_rdata", rsp_rdata, e[15:0]);
      chk("rsp_err", rsp_err, e[16]);
      chk("resp_en_n", {mem_we_even_n, mem_we_odd_n}, 2'b11);
      if (h < hold) tick;
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    chk("rsp_valid_done", rsp_valid, 0);
    chk("req_ready_back", req_ready, 1);
  endtask

  initial begin
    tick;
    tick;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_word", mem_word, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_en_n", {mem_we_even_n, mem_we_odd_n}, 2'b11);
    reset = 1'b1;
    tick;

    // word load, ready on first ACCESS cycle
    do_req(1'b0, 1'b1, 16'h0040, 16'h0000, 16'hBEEF, 0, 16'hBEEF, 1'b0, 2, 2'b11, 16'h0000, 0);
    // byte loads, odd lane negative then even lane positive
    do_req(1'b0, 1'b0, 16'h0041, 16'h0000, 16'h8012, 0, 16'hFF80, 1'b0, 2, 2'b11, 16'h0000, 0);
    do_req(1'b0, 1'b0, 16'h0040, 16'h0000, 16'h8012, 0, 16'h0012, 1'b0, 2, 2'b11, 16'h0000, 0);
    // byte stores to odd and even lanes
    do_req(1'b1, 1'b0, 16'h0043, 16'h00A5, 16'hFFFF, 0, 16'h0000, 1'b0, 2, 2'b10, 16'hA5A5, 0);
    do_req(1'b1, 1'b0, 16'h0042, 16'h773C, 16'hFFFF, 1, 16'h0000, 1'b0, 3, 2'b01, 16'h3C3C, 0);
    // word store with two ready-low cycles
    do_req(1'b1, 1'b1, 16'h0044, 16'h1234, 16'hFFFF, 2, 16'h0000, 1'b0, 4, 2'b00, 16'h1234, 0);
    // unaligned word store: immediate error, no memory cycle
    do_req(1'b1, 1'b1, 16'h0011, 16'h5555, 16'hFFFF, 0, 16'h0000, 1'b1, 1, 2'b11, 16'h5555, 0);
    // timeout with WAIT_MAX=4, response held for 3 cycles
    do_req(1'b0, 1'b1, 16'h0080, 16'h0000, 16'hCAFE, 99, 16'h0000, 1'b1, 5, 2'b11, 16'h0000, 3);

    // reset in the second ACCESS cycle of a word store
    req_valid = 1'b1; req_we = 1'b1; req_word = 1'b1; req_addr = 16'h0050; req_wdata = 16'h1234;
    mem_ready = 1'b0;
    tick;
    req_valid = 1'b0;
    chk("mid_en_n_c1", {mem_we_even_n, mem_we_odd_n}, 2'b00);
    tick;
    chk("mid_en_n_c2", {mem_we_even_n, mem_we_odd_n}, 2'b00);
    reset = 1'b0;
    tick;
    reset = 1'b1;
    chk("mid_rst_req_ready", req_ready, 1);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_en_n", {mem_we_even_n, mem_we_odd_n}, 2'b11);
    chk("mid_rst_mem_addr", mem_addr, 0);
    chk("mid_rst_mem_wdata", mem_wdata, 0);
    // fresh request after reset
    do_req(1'b0, 1'b1, 16'h0060, 16'h0000, 16'h5A5A, 1, 16'h5A5A, 1'b0, 3, 2'b11, 16'h0000, 0);

    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
